// File: rtl/seg7_capture_if.sv
// Display-side bundle for seg7_capture: sampled anode/segment lines in,
// recovered frame and status pulses out.
interface seg7_capture_if;
  logic [3:0]  anode_in;
  logic [6:0]  seg_in;
  logic [15:0] BCD_out;
  logic        frame_valid;
  logic [3:0]  digit_mask;
  logic        seg_error;
  logic        anode_error;
  logic        stale;

  modport master (
    output anode_in, seg_in,
    input  BCD_out, frame_valid, digit_mask, seg_error, anode_error, stale
  );

  modport slave (
    input  anode_in, seg_in,
    output BCD_out, frame_valid, digit_mask, seg_error, anode_error, stale
  );
endinterface

// File: rtl/seg7_capture.sv
// Recovers the 16-bit hex value shown on a 4-digit multiplexed 7-segment display.
// Optional stale-frame watchdog is built only when SEG7_CAP_STALE_EN is defined.
module seg7_capture #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STALE_CYCLES  = 4194304
) (
  input logic           clk_100mhz,
  input logic           rst,
  seg7_capture_if.slave disp
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 2 || STALE_CYCLES < 2) begin : g_param_check
    $error("seg7_capture: SETTLE_CYCLES and STALE_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_e;

  function automatic logic anode_is_legal(input logic [3:0] a);
    case (a)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: anode_is_legal = 1'b1;
      default:                            anode_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic anode_is_illegal(input logic [3:0] a);
    anode_is_illegal = (a != 4'b1111) && !anode_is_legal(a);
  endfunction

  function automatic logic [1:0] anode_index(input logic [3:0] a);
    case (a)
      4'b0111: anode_index = 2'd3;
      4'b1011: anode_index = 2'd2;
      4'b1101: anode_index = 2'd1;
      default: anode_index = 2'd0;
    endcase
  endfunction

  // Inverse of the hex-to-segment table; bit 4 flags a recognised pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: seg_decode = {1'b1, 4'h0};
      7'b1001111: seg_decode = {1'b1, 4'h1};
      7'b0010010: seg_decode = {1'b1, 4'h2};
      7'b0000110: seg_decode = {1'b1, 4'h3};
      7'b1001100: seg_decode = {1'b1, 4'h4};
      7'b0100100: seg_decode = {1'b1, 4'h5};
      7'b0100000: seg_decode = {1'b1, 4'h6};
      7'b0001111: seg_decode = {1'b1, 4'h7};
      7'b0000000: seg_decode = {1'b1, 4'h8};
      7'b0000100: seg_decode = {1'b1, 4'h9};
      7'b0001000: seg_decode = {1'b1, 4'hA};
      7'b1100000: seg_decode = {1'b1, 4'hB};
      7'b0110001: seg_decode = {1'b1, 4'hC};
      7'b1000010: seg_decode = {1'b1, 4'hD};
      7'b0110000: seg_decode = {1'b1, 4'hE};
      7'b0111000: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  logic [3:0]  anode_meta_q, anode_sync_q;
  logic [6:0]  seg_meta_q, seg_sync_q;
  logic [10:0] prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic [15:0] staging_q, staging_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] bcd_q, bcd_d;
  logic        frame_valid_q, frame_valid_d;
  logic        seg_error_q, seg_error_d;
  logic        anode_error_q, anode_error_d;

  logic [10:0] cur_sample;
  logic        stable;
  logic        anode_legal;
  logic        capture_en;
  logic [4:0]  dec;
  logic [1:0]  dig_idx;
  logic [3:0]  mask_set;

  assign cur_sample  = {anode_sync_q, seg_sync_q};
  assign stable      = (cur_sample == prev_q);
  assign anode_legal = anode_is_legal(anode_sync_q);
  assign dec         = seg_decode(seg_sync_q);
  assign dig_idx     = anode_index(anode_sync_q);
  assign mask_set    = mask_q | (4'b0001 << dig_idx);

  // Synchronizers and history idle at the blank/all-dark pattern so that
  // leaving reset never looks like an illegal anode.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      anode_meta_q <= 4'b1111;
      anode_sync_q <= 4'b1111;
      seg_meta_q   <= 7'b1111111;
      seg_sync_q   <= 7'b1111111;
      prev_q       <= 11'h7FF;
      cnt_q        <= '0;
    end else begin
      anode_meta_q <= disp.anode_in;
      anode_sync_q <= anode_meta_q;
      seg_meta_q   <= disp.seg_in;
      seg_sync_q   <= seg_meta_q;
      prev_q       <= cur_sample;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!stable)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    capture_en = 1'b0;
    case (state_q)
      IDLE:    if (anode_legal) state_d = SETTLE;
      SETTLE: begin
        if (!stable) begin
          state_d = anode_legal ? SETTLE : IDLE;
        end else if (cnt_q == CNT_MAX) begin
          capture_en = 1'b1;
          state_d    = HELD;
        end
      end
      HELD:    if (!stable) state_d = anode_legal ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
    if (!anode_legal) begin
      state_d    = IDLE;
      capture_en = 1'b0;
    end
  end

  // Capture and frame assembly; the completing nibble goes straight into BCD.
  always_comb begin
    staging_d     = staging_q;
    mask_d        = mask_q;
    bcd_d         = bcd_q;
    frame_valid_d = 1'b0;
    seg_error_d   = 1'b0;
    anode_error_d = anode_is_illegal(anode_sync_q) && !anode_is_illegal(prev_q[10:7]);
    if (capture_en) begin
      if (dec[4]) begin
        staging_d[{dig_idx, 2'b00} +: 4] = dec[3:0];
        if (mask_set == 4'b1111) begin
          bcd_d         = staging_d;
          frame_valid_d = 1'b1;
          mask_d        = 4'b0000;
        end else begin
          mask_d = mask_set;
        end
      end else begin
        seg_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      staging_q     <= '0;
      mask_q        <= '0;
      bcd_q         <= '0;
      frame_valid_q <= 1'b0;
      seg_error_q   <= 1'b0;
      anode_error_q <= 1'b0;
    end else begin
      staging_q     <= staging_d;
      mask_q        <= mask_d;
      bcd_q         <= bcd_d;
      frame_valid_q <= frame_valid_d;
      seg_error_q   <= seg_error_d;
      anode_error_q <= anode_error_d;
    end
  end

  assign disp.BCD_out     = bcd_q;
  assign disp.frame_valid = frame_valid_q;
  assign disp.digit_mask  = mask_q;
  assign disp.seg_error   = seg_error_q;
  assign disp.anode_error = anode_error_q;

`ifdef SEG7_CAP_STALE_EN
  localparam int unsigned STALE_W = $clog2(STALE_CYCLES);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES - 1);

  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;

  // Saturating watchdog; stale is simply "counter parked at its ceiling".
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    if (frame_valid_d)
      stale_cnt_d = '0;
    else if (stale_cnt_q != STALE_MAX)
      stale_cnt_d = stale_cnt_q + STALE_W'(1);
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) stale_cnt_q <= '0;
    else     stale_cnt_q <= stale_cnt_d;
  end

  assign disp.stale = (stale_cnt_q == STALE_MAX);
`else
  assign disp.stale = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed-vector bench for seg7_capture: frames, glitches, bad segments,
// bad anodes, mid-frame reset and (when built with it) the stale watchdog.
module tb_seg7_capture;

  localparam logic [3:0] AN_D3 = 4'b0111;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_BL = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_BAD = 7'b1111110;

  logic clk_100mhz = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int fv_total = 0;
  int se_total = 0;
  int ae_total = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  seg7_capture_if disp ();

  seg7_capture #(
    .SETTLE_CYCLES(16),
    .STALE_CYCLES (100)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .disp      (disp)
  );

  always @(negedge clk_100mhz) begin
    if (disp.frame_valid) fv_total++;
    if (disp.seg_error)   se_total++;
    if (disp.anode_error) ae_total++;
  end

  task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
    @(negedge clk_100mhz);
    disp.anode_in = an;
    disp.seg_in   = sg;
    repeat (n) @(negedge clk_100mhz);
  endtask

  task automatic apply_reset();
    disp.anode_in = AN_BL;
    disp.seg_in   = SEG_OFF;
    rst = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) @(negedge clk_100mhz);
    vectors++;
    if (disp.BCD_out !== 16'h0000) begin
      miscompares++; $display("FAIL reset_bcd: got %h expected 0000", disp.BCD_out);
    end
    vectors++;
    if (disp.digit_mask !== 4'b0000) begin
      miscompares++; $display("FAIL reset_mask: got %b expected 0000", disp.digit_mask);
    end
    vectors++;
    if ({disp.frame_valid, disp.seg_error, disp.anode_error, disp.stale} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000",
               {disp.frame_valid, disp.seg_error, disp.anode_error, disp.stale});
    end
  endtask

  task automatic test_frame_1234();
    int fv0 = fv_total;
    @(negedge clk_100mhz);
    disp.anode_in = AN_D3;
    disp.seg_in   = SEG_1;
    repeat (18) @(negedge clk_100mhz);
    vectors++;
    if (disp.digit_mask !== 4'b0000) begin
      miscompares++; $display("FAIL latency_early: got %b expected 0000", disp.digit_mask);
    end
    @(negedge clk_100mhz);
    vectors++;
    if (disp.digit_mask !== 4'b1000) begin
      miscompares++; $display("FAIL latency_capture: got %b expected 1000", disp.digit_mask);
    end
    repeat (21) @(negedge clk_100mhz);
    hold(AN_D2, SEG_2, 40);
    vectors++;
    if (disp.digit_mask !== 4'b1100) begin
      miscompares++; $display("FAIL mask_two_digits: got %b expected 1100", disp.digit_mask);
    end
    hold(AN_D1, SEG_3, 40);
    hold(AN_D0, SEG_4, 40);
    hold(AN_BL, SEG_OFF, 20);
    vectors++;
    if (fv_total - fv0 !== 1) begin
      miscompares++; $display("FAIL frame_1234_count: got %0d expected 1", fv_total - fv0);
    end
    vectors++;
    if (disp.BCD_out !== 16'h1234) begin
      miscompares++; $display("FAIL frame_1234_value: got %h expected 1234", disp.BCD_out);
    end
    vectors++;
    if (disp.digit_mask !== 4'b0000) begin
      miscompares++; $display("FAIL frame_1234_mask: got %b expected 0000", disp.digit_mask);
    end
  endtask

  task automatic test_glitch_abcd();
    int fv0 = fv_total;
    hold(AN_D0, SEG_8, 5);
    hold(AN_D3, SEG_A, 40);
    hold(AN_D1, SEG_0, 6);
    hold(AN_D2, SEG_B, 40);
    hold(AN_D2, SEG_7, 3);
    hold(AN_D1, SEG_C, 40);
    vectors++;
    if (disp.digit_mask !== 4'b1110) begin
      miscompares++; $display("FAIL glitch_mask: got %b expected 1110", disp.digit_mask);
    end
    hold(AN_D3, SEG_8, 10);
    hold(AN_D0, SEG_D, 40);
    hold(AN_BL, SEG_OFF, 20);
    vectors++;
    if (fv_total - fv0 !== 1) begin
      miscompares++; $display("FAIL glitch_frame_count: got %0d expected 1", fv_total - fv0);
    end
    vectors++;
    if (disp.BCD_out !== 16'hABCD) begin
      miscompares++; $display("FAIL glitch_value: got %h expected abcd", disp.BCD_out);
    end
  endtask

  task automatic test_seg_error();
    int fv0 = fv_total;
    int se0 = se_total;
    hold(AN_D3, SEG_1, 40);
    hold(AN_D2, SEG_2, 40);
    hold(AN_D1, SEG_BAD, 40);
    vectors++;
    if (se_total - se0 !== 1) begin
      miscompares++; $display("FAIL seg_error_count: got %0d expected 1", se_total - se0);
    end
    vectors++;
    if (disp.digit_mask !== 4'b1100) begin
      miscompares++; $display("FAIL seg_error_mask: got %b expected 1100", disp.digit_mask);
    end
    hold(AN_D0, SEG_4, 40);
    vectors++;
    if (disp.digit_mask !== 4'b1101 || fv_total != fv0) begin
      miscompares++;
      $display("FAIL seg_error_no_frame: got mask %b frames %0d expected mask 1101 frames 0",
               disp.digit_mask, fv_total - fv0);
    end
    hold(AN_D1, SEG_3, 40);
    hold(AN_BL, SEG_OFF, 20);
    vectors++;
    if (fv_total - fv0 !== 1 || disp.BCD_out !== 16'h1234) begin
      miscompares++;
      $display("FAIL seg_error_recover: got frames %0d value %h expected frames 1 value 1234",
               fv_total - fv0, disp.BCD_out);
    end
  endtask

  task automatic test_anode_error();
    int fv0 = fv_total;
    int ae0 = ae_total;
    int se0 = se_total;
    hold(4'b0011, SEG_8, 40);
    vectors++;
    if (ae_total - ae0 !== 1) begin
      miscompares++; $display("FAIL anode_error_count: got %0d expected 1", ae_total - ae0);
    end
    vectors++;
    if (disp.digit_mask !== 4'b0000 || fv_total != fv0 || se_total != se0) begin
      miscompares++;
      $display("FAIL anode_error_no_capture: got mask %b frames %0d seg_err %0d expected 0000 0 0",
               disp.digit_mask, fv_total - fv0, se_total - se0);
    end
    hold(AN_BL, SEG_OFF, 40);
    vectors++;
    if (ae_total - ae0 !== 1) begin
      miscompares++; $display("FAIL blank_no_error: got %0d expected 1", ae_total - ae0);
    end
    vectors++;
    if (disp.BCD_out !== 16'h1234) begin
      miscompares++; $display("FAIL anode_error_bcd_hold: got %h expected 1234", disp.BCD_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    hold(AN_D3, SEG_0, 40);
    hold(AN_D2, SEG_0, 40);
    hold(AN_D1, SEG_F, 40);
    hold(AN_D0, SEG_F, 40);
    vectors++;
    if (disp.BCD_out !== 16'h00FF) begin
      miscompares++; $display("FAIL frame_00ff: got %h expected 00ff", disp.BCD_out);
    end
    hold(AN_D3, SEG_E, 40);
    hold(AN_D2, SEG_0, 40);
    vectors++;
    if (disp.digit_mask !== 4'b1100) begin
      miscompares++; $display("FAIL partial_mask: got %b expected 1100", disp.digit_mask);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (disp.BCD_out !== 16'h0000 || disp.digit_mask !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset: got bcd %h mask %b expected 0000 0000",
               disp.BCD_out, disp.digit_mask);
    end
    apply_reset();
    fv0 = fv_total;
    hold(AN_D3, SEG_E, 40);
    hold(AN_D2, SEG_0, 40);
    hold(AN_D1, SEG_0, 40);
    hold(AN_D0, SEG_8, 40);
    hold(AN_BL, SEG_OFF, 20);
    vectors++;
    if (fv_total - fv0 !== 1 || disp.BCD_out !== 16'hE008) begin
      miscompares++;
      $display("FAIL frame_after_reset: got frames %0d value %h expected frames 1 value e008",
               fv_total - fv0, disp.BCD_out);
    end
  endtask

`ifdef SEG7_CAP_STALE_EN
  task automatic test_stale();
    apply_reset();
    repeat (98) @(negedge clk_100mhz);
    vectors++;
    if (disp.stale !== 1'b0) begin
      miscompares++; $display("FAIL stale_early: got %b expected 0", disp.stale);
    end
    @(negedge clk_100mhz);
    vectors++;
    if (disp.stale !== 1'b1) begin
      miscompares++; $display("FAIL stale_rise: got %b expected 1", disp.stale);
    end
    repeat (21) @(negedge clk_100mhz);
    hold(AN_D3, SEG_1, 40);
    hold(AN_D2, SEG_2, 40);
    hold(AN_D1, SEG_3, 40);
    hold(AN_D0, SEG_4, 40);
    hold(AN_BL, SEG_OFF, 20);
    vectors++;
    if (disp.stale !== 1'b0) begin
      miscompares++; $display("FAIL stale_clear: got %b expected 0", disp.stale);
    end
  endtask
`endif

  initial begin
    disp.anode_in = AN_BL;
    disp.seg_in   = SEG_OFF;
    test_reset();
    test_frame_1234();
    test_glitch_abcd();
    test_seg_error();
    test_anode_error();
    test_reset_mid_frame();
`ifdef SEG7_CAP_STALE_EN
    test_stale();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
